// File: rtl/calendar_datapath_if.sv
// Signal bundle between the clock control unit / display formatter and the calendar datapath.
// The master drives the enables, edit requests and blink code; the slave returns the field values.
interface calendar_datapath_if;
    logic       tick_1hz;
    logic       run_en;
    logic       up_s;
    logic       down_s;
    logic       up_m;
    logic       down_m;
    logic       up_h;
    logic       down_h;
    logic       up_d;
    logic       down_d;
    logic       up_mo;
    logic       down_mo;
    logic       up_y;
    logic       down_y;
    logic [2:0] blink;
    logic       tick_blink;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] day;
    logic [3:0] month;
    logic [6:0] year;
    logic [5:0] blank;
    logic       century_wrap;

    modport master (
        output tick_1hz, run_en,
        output up_s, down_s, up_m, down_m, up_h, down_h,
        output up_d, down_d, up_mo, down_mo, up_y, down_y,
        output blink, tick_blink,
        input  sec, min, hour, day, month, year, blank, century_wrap
    );

    modport slave (
        input  tick_1hz, run_en,
        input  up_s, down_s, up_m, down_m, up_h, down_h,
        input  up_d, down_d, up_mo, down_mo, up_y, down_y,
        input  blink, tick_blink,
        output sec, min, hour, day, month, year, blank, century_wrap
    );
endinterface

// File: rtl/calendar_datapath.sv
// Calendar timekeeping for 2000-2099: 1 Hz carry chain while running, single-step
// non-carrying field edits with day clamping while setting, and per-field blink blanking.
module calendar_datapath #(
    parameter int RESET_YEAR  = 0,
    parameter int RESET_MONTH = 1,
    parameter int RESET_DAY   = 1
) (
    input logic                clk,
    input logic                rst,
    calendar_datapath_if.slave bus
);

    localparam logic [6:0] INIT_YEAR  = 7'(RESET_YEAR);
    localparam logic [3:0] INIT_MONTH = 4'(RESET_MONTH);
    localparam logic [4:0] INIT_DAY   = 5'(RESET_DAY);

    logic [5:0]  sec_r, sec_n;
    logic [5:0]  min_r, min_n;
    logic [4:0]  hour_r, hour_n;
    logic [4:0]  day_r, day_n;
    logic [3:0]  month_r, month_n;
    logic [6:0]  year_r, year_n;
    logic [5:0]  blank_r, blank_n;
    logic        wrap_r, wrap_n;

    logic [11:0] req;
    logic [11:0] req_p0;
    logic [11:0] rise;

    logic [4:0]  dim_cur;
    logic [4:0]  dim_new;
    logic [4:0]  day_step;

    // Leap rule reduces to year % 4 == 0 inside a single century starting at 2000.
    function automatic logic [4:0] days_in_month(input logic [3:0] mo, input logic [1:0] yr_lo);
        case (mo)
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            4'd2:                    days_in_month = (yr_lo == 2'd0) ? 5'd29 : 5'd28;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

    function automatic logic [6:0] step_field(
        input logic [6:0] val,
        input logic [6:0] lo,
        input logic [6:0] hi,
        input logic       inc,
        input logic       dec
    );
        step_field = val;
        if (inc && !dec) begin
            step_field = (val == hi) ? lo : val + 7'd1;
        end else if (dec && !inc) begin
            step_field = (val == lo) ? hi : val - 7'd1;
        end
    endfunction

    assign req = {bus.down_y, bus.up_y, bus.down_mo, bus.up_mo, bus.down_d, bus.up_d,
                  bus.down_h, bus.up_h, bus.down_m, bus.up_m, bus.down_s, bus.up_s};

    // History tracks requests in every mode, so a level held across a run_en change never fires.
    assign rise = req & ~req_p0 & {12{~bus.run_en}};

    assign dim_cur = days_in_month(month_r, year_r[1:0]);

    always_comb begin
        sec_n    = sec_r;
        min_n    = min_r;
        hour_n   = hour_r;
        day_n    = day_r;
        month_n  = month_r;
        year_n   = year_r;
        wrap_n   = 1'b0;
        dim_new  = dim_cur;
        day_step = day_r;

        if (bus.run_en) begin
            if (bus.tick_1hz) begin
                if (sec_r != 6'd59) begin
                    sec_n = sec_r + 6'd1;
                end else begin
                    sec_n = 6'd0;
                    if (min_r != 6'd59) begin
                        min_n = min_r + 6'd1;
                    end else begin
                        min_n = 6'd0;
                        if (hour_r != 5'd23) begin
                            hour_n = hour_r + 5'd1;
                        end else begin
                            hour_n = 5'd0;
                            if (day_r < dim_cur) begin
                                day_n = day_r + 5'd1;
                            end else begin
                                day_n = 5'd1;
                                if (month_r != 4'd12) begin
                                    month_n = month_r + 4'd1;
                                end else begin
                                    month_n = 4'd1;
                                    if (year_r != 7'd99) begin
                                        year_n = year_r + 7'd1;
                                    end else begin
                                        year_n = 7'd0;
                                        wrap_n = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
            end
        end else begin
            sec_n    = 6'(step_field({1'b0, sec_r}, 7'd0, 7'd59, rise[0], rise[1]));
            min_n    = 6'(step_field({1'b0, min_r}, 7'd0, 7'd59, rise[2], rise[3]));
            hour_n   = 5'(step_field({2'b0, hour_r}, 7'd0, 7'd23, rise[4], rise[5]));
            day_step = 5'(step_field({2'b0, day_r}, 7'd1, {2'b0, dim_cur}, rise[6], rise[7]));
            month_n  = 4'(step_field({3'b0, month_r}, 7'd1, 7'd12, rise[8], rise[9]));
            year_n   = step_field(year_r, 7'd0, 7'd99, rise[10], rise[11]);
            // Day is stepped against the old month length, then pulled into the new one.
            dim_new  = days_in_month(month_n, year_n[1:0]);
            day_n    = (day_step > dim_new) ? dim_new : day_step;
        end
    end

    always_comb begin
        blank_n = '0;
        for (int i = 0; i < 6; i++) begin
            blank_n[i] = bus.tick_blink && (bus.blink == 3'(i + 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_r   <= 6'd0;
            min_r   <= 6'd0;
            hour_r  <= 5'd0;
            day_r   <= INIT_DAY;
            month_r <= INIT_MONTH;
            year_r  <= INIT_YEAR;
            blank_r <= '0;
            wrap_r  <= 1'b0;
            req_p0  <= '0;
        end else begin
            sec_r   <= sec_n;
            min_r   <= min_n;
            hour_r  <= hour_n;
            day_r   <= day_n;
            month_r <= month_n;
            year_r  <= year_n;
            blank_r <= blank_n;
            wrap_r  <= wrap_n;
            req_p0  <= req;
        end
    end

    assign bus.sec          = sec_r;
    assign bus.min          = min_r;
    assign bus.hour         = hour_r;
    assign bus.day          = day_r;
    assign bus.month        = month_r;
    assign bus.year         = year_r;
    assign bus.blank        = blank_r;
    assign bus.century_wrap = wrap_r;

endmodule

// File: doc/calendar_datapath.md
Name: calendar_datapath

Overview:
- Timekeeping datapath that consumes the setting-mode outputs of the clock's control unit: per-field up/down strobes, the `blink` code and `tick_blink`.
- Holds seconds, minutes, hours, day, month and year-of-century (2000–2099).
- Advances the calendar on a 1 Hz enable while running, and applies single-step, non-carrying field edits while in setting mode.
- Drives the display formatter with binary field values and per-field blanking.

Parameters:
RESET_YEAR, 0, year-of-century loaded on reset (0..99)
RESET_MONTH, 1, month loaded on reset (1..12)
RESET_DAY, 1, day loaded on reset; must be valid for RESET_MONTH/RESET_YEAR

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick_1hz  in  1  one-cycle 1 Hz enable
run_en  in  1  1 = running (tick honoured, edits ignored); 0 = setting mode (tick ignored, edits honoured)
up_s, down_s  in  1  second edit request (level)
up_m, down_m  in  1  minute edit request
up_h, down_h  in  1  hour edit request
up_d, down_d  in  1  day edit request
up_mo, down_mo  in  1  month edit request
up_y, down_y  in  1  year edit request
blink  in  3  field under edit: 001 sec, 010 min, 011 hour, 100 day, 101 month, 110 year, other = none
tick_blink  in  1  blink phase
sec, min  out  6  0..59
hour  out  5  0..23
day  out  5  1..28/29/30/31
month  out  4  1..12
year  out  7  0..99 (calendar year 2000+year)
blank  out  6  per-field blank: bit0 sec .. bit5 year
century_wrap  out  1  one-cycle pulse on 2099→2000 rollover

Behaviour:
- **Reset** (rst=1 at a clk edge):
  - sec=min=hour=0; day=RESET_DAY; month=RESET_MONTH; year=RESET_YEAR.
  - blank=0; century_wrap=0.
  - All edge-detect history registers cleared to 0.
  - Reset has priority over tick and edits, including a reset arriving mid-carry or mid-edit.
- **Outputs:** all registered; an update is visible after the clk edge on which its cause is sampled (1-cycle latency).
- **Days in month (dim):**
  - 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11.
  - Feb: 29 if year[1:0]==0, else 28. Valid for 2000–2099 only.
- **Running** (run_en=1, tick_1hz=1):
  - sec+1. At 59: sec=0 and carry to min.
  - min 59→0 carries to hour; hour 23→0 carries to day.
  - day==dim → day=1, carry to month; month 12→1, carry to year.
  - year 99→0 and century_wrap=1 for exactly one cycle.
  - The full carry chain resolves in the same edge.
- **Running, no tick** (run_en=1, tick_1hz=0): no change. Edit inputs are ignored but their edge history keeps updating.
- **Setting mode** (run_en=0):
  - tick_1hz is ignored; time does not advance.
- **Edit edge detection:**
  - An edit fires on the rising edge of a request: request=1 and its registered previous value=0.
  - A held request yields exactly one step.
  - up and down rising in the same cycle for one field → no change.
  - Different fields requested in the same cycle are each applied independently.
- **Edit arithmetic:**
  - Edits wrap within the field and never carry: sec/min 0↔59, hour 0↔23, day 1↔dim, month 1↔12, year 0↔99.
  - Day wrap uses dim of the current month/year.
- **Day clamp:**
  - After a month or year edit, if day > new dim, day=new dim in the same edge. Example: Jan 31 → month up → Feb 29 (leap) or 28.
  - When day and month/year edits land in the same cycle, day is stepped first against the old dim, then clamped.
- **run_en transitions:**
  - 1→0: takes effect the same cycle. A tick coincident with run_en=0 is dropped.
  - 0→1: no step is applied for requests already high.
- **Blanking:** blank[i] = tick_blink AND (blink decodes to field i), registered. Codes 000 and 111 → blank=0.
- **century_wrap:** never asserted by an edit (year 99→0 via up_y does not pulse).

Test Plan:
1. Reset with defaults → 00:00:00, day 1, month 1, year 0, blank=0. Assert rst mid-edit → same values on the next edge.
2. run_en=1, set 2099-12-31 23:59:59, one tick → 2000-01-01 00:00:00, century_wrap=1 for one cycle then 0.
3. Leap rollover:
   - 2024-02-28 23:59:59 + tick → 2024-02-29 00:00:00.
   - 2023-02-28 23:59:59 + tick → 2023-03-01.
4. run_en=0, hold up_s high 10 cycles from sec=59 → sec=0 after one edge, stays 0, min unchanged. Then up_s and down_s rising together → no change.
5. Clamp:
   - run_en=0, 2024-01-31, up_mo pulse → month 2, day 29.
   - down_y pulse → year 23, day 28.
   - day 1 + down_d → day 28.
6. Mode gating and blanking:
   - run_en=1 with up_h pulse → hour unchanged.
   - run_en=0 with tick_1hz → sec unchanged.
   - blink=011, tick_blink toggling → blank alternates 000100/000000; blink=111 → blank=0.
